// File: rtl/mult_sequencer_pkg.sv
// Shared encodings for the multiply sequencer: ALU operation codes and controller states.
package mult_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_SLT = 3'b100,
    ALU_NOR = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/result bundle between the core control and the multiply sequencer.
interface mult_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, multiplicand, multiplier,
    input  ready, busy, done, hi, lo
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output ready, busy, done, hi, lo
  );
endinterface

// File: rtl/mult_sequencer.sv
// Unsigned WIDTHxWIDTH shift-add multiplier that borrows the shared ALU for the adds,
// producing the 2*WIDTH product in HI:LO after WIDTH iterations.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNT_W      = 6,
  parameter logic [2:0]  ALU_OP_ADD = ALU_ADD
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_sequencer_if.slave      bus,
  output logic [2:0]           alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_result
);

  state_e           state, next_state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             carry;
  logic             last_iter;

  assign accept    = bus.ready && bus.start;
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  assign alu_op = ALU_OP_ADD;
  assign alu_a  = hi;
  assign alu_b  = lo[0] ? m_reg : '0;

  // Carry-out of the ALU add recovered by wrap-around detection; no add means no carry.
  assign carry = (alu_b != '0) && (alu_result < alu_a);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (last_iter) next_state = DONE;
      DONE:    next_state = bus.start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (state)
      IDLE:    bus.ready = 1'b1;
      RUN:     bus.busy  = 1'b1;
      DONE: begin
        bus.ready = 1'b1;
        bus.done  = 1'b1;
      end
      default: bus.ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_reg <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
    end else if (accept) begin
      m_reg <= bus.multiplicand;
      hi    <= '0;
      lo    <= bus.multiplier;
      count <= '0;
    end else if (state == RUN) begin
      // LO doubles as the multiplier shift register: its LSB selects the add, the sum bit enters at the top.
      {hi, lo} <= {carry, alu_result, lo[WIDTH-1:1]};
      count    <= count + 1'b1;
    end
  end

  assign bus.hi = hi;
  assign bus.lo = lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomised self-checking bench for mult_sequencer driving a behavioural shared ALU.
module tb_mult_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  int           checks = 0;
  int           passes = 0;

  mult_sequencer_if #(.WIDTH(W)) bus ();

  mult_sequencer #(.WIDTH(W), .CNT_W(6), .ALU_OP_ADD(3'b010)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Shared datapath ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_a - alu_b;
      3'b100:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      3'b101:  alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    return 64'(m) * 64'(q);
  endfunction

  // Pulses start for one cycle, then counts negedges until done (33 expected), -1 on timeout.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = m; bus.multiplier = q;
    @(negedge clk);
    bus.start = 1'b0; bus.multiplicand = $urandom; bus.multiplier = $urandom;
    lat = 1;
    while (!bus.done && lat < 45) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100)
      $display("FAIL reset_flags got %b want 100", {bus.ready, bus.busy, bus.done});
    else passes++;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {bus.hi, bus.lo});
    else passes++;
    checks++;
    if (alu_op !== 3'b010 || alu_b !== '0)
      $display("FAIL reset_alu got op=%b b=%h want op=010 b=0", alu_op, alu_b);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [63:0] p;
    run_op(32'd3, 32'd5, lat);
    checks++;
    if (lat != 33) $display("FAIL basic_latency got %0d want 33", lat);
    else passes++;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_0000_000F)
      $display("FAIL basic_product got %h want 000000000000000f", {bus.hi, bus.lo});
    else passes++;
    checks++;
    if (bus.ready !== 1'b1) $display("FAIL basic_ready_in_done got %b want 1", bus.ready);
    else passes++;
    p = {bus.hi, bus.lo};
    @(negedge clk);
    checks++;
    if ({bus.done, bus.ready, bus.hi, bus.lo} !== {1'b0, 1'b1, 64'hF} || p !== 64'hF)
      $display("FAIL basic_hold got done=%b ready=%b %h want 0 1 f", bus.done, bus.ready, {bus.hi, bus.lo});
    else passes++;
  endtask

  task automatic test_max();
    int lat;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat != 33 || {bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL max_product got lat=%0d %h want 33 fffffffe00000001", lat, {bus.hi, bus.lo});
    else passes++;
  endtask

  task automatic test_zero();
    int k;
    bit b_seen;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'h1234_5678; bus.multiplier = 32'h0;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1; b_seen = 1'b0;
    while (!bus.done && k < 45) begin
      if (bus.busy && alu_b !== '0) b_seen = 1'b1;
      @(negedge clk);
      k++;
    end
    checks++;
    if (b_seen) $display("FAIL zero_alu_b got nonzero alu_b want 0 throughout");
    else passes++;
    checks++;
    if (k != 33 || {bus.hi, bus.lo} !== 64'h0)
      $display("FAIL zero_q_product got lat=%0d %h want 33 0", k, {bus.hi, bus.lo});
    else passes++;
    run_op(32'h0, 32'hDEAD_BEEF, k);
    checks++;
    if (k != 33 || {bus.hi, bus.lo} !== 64'h0)
      $display("FAIL zero_m_product got lat=%0d %h want 33 0", k, {bus.hi, bus.lo});
    else passes++;
  endtask

  task automatic test_start_while_busy();
    int k, nb;
    logic [31:0] m, q;
    m = $urandom; q = $urandom;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = m; bus.multiplier = q;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1; nb = 0;
    while (!bus.done && k < 45) begin
      if (bus.busy) nb++;
      bus.start = (k == 10);
      bus.multiplicand = $urandom; bus.multiplier = $urandom;
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    checks++;
    if (nb != 32 || k != 33) $display("FAIL busy_len got busy=%0d lat=%0d want 32 33", nb, k);
    else passes++;
    checks++;
    if ({bus.hi, bus.lo} !== ref_mul(m, q))
      $display("FAIL busy_ignore got %h want %h", {bus.hi, bus.lo}, ref_mul(m, q));
    else passes++;
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = $urandom | 32'h1; bus.multiplier = $urandom | 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100 || {bus.hi, bus.lo} !== 64'h0)
      $display("FAIL abort_state got rbd=%b %h want 100 0", {bus.ready, bus.busy, bus.done}, {bus.hi, bus.lo});
    else passes++;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL abort_no_done got done pulse want none");
    else passes++;
    run_op(32'd7, 32'd9, lat);
    checks++;
    if (lat != 33 || {bus.hi, bus.lo} !== 64'd63)
      $display("FAIL abort_then_7x9 got lat=%0d %h want 33 63", lat, {bus.hi, bus.lo});
    else passes++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] m, q;
    m = $urandom; q = $urandom;
    run_op(m, q, lat);
    checks++;
    if (lat != 33 || {bus.hi, bus.lo} !== ref_mul(m, q))
      $display("FAIL b2b_first got lat=%0d %h want 33 %h", lat, {bus.hi, bus.lo}, ref_mul(m, q));
    else passes++;
    bus.start = 1'b1; bus.multiplicand = 32'h0001_0000; bus.multiplier = 32'h0001_0000;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.ready} !== 2'b10)
      $display("FAIL b2b_no_gap got busy/ready=%b want 10", {bus.busy, bus.ready});
    else passes++;
    lat = 1;
    while (!bus.done && lat < 45) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 33 || {bus.hi, bus.lo} !== 64'h0000_0001_0000_0000)
      $display("FAIL b2b_second got lat=%0d %h want 33 0000000100000000", lat, {bus.hi, bus.lo});
    else passes++;
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] m, q;
    for (int i = 0; i < 12; i++) begin
      m = $urandom; q = $urandom;
      if (i == 0) m = 32'h8000_0000;
      if (i == 1) q = 32'h8000_0001;
      run_op(m, q, lat);
      checks++;
      if (lat != 33 || {bus.hi, bus.lo} !== ref_mul(m, q))
        $display("FAIL random_%0d got lat=%0d %h want 33 %h (m=%h q=%h)",
                 i, lat, {bus.hi, bus.lo}, ref_mul(m, q), m, q);
      else passes++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
